// File: rtl/if_stage_pkg.sv
// Shared fetch-stage constants and types: NOP/HALT encodings, run state, IF/ID payload.
// Pure declarations, no logic and no latency.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] next_pc;
        logic [31:0] instr;
    } ifid_t;

endpackage

// File: rtl/if_stage_instruction_memory.sv
// Instruction RAM: one synchronous write port and an asynchronous read port.
// Latency: read is combinational, a write is visible from the next cycle; no backpressure.
module instruction_memory #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_dat_o
);

    logic [31:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC, instruction RAM read, IF/ID register and HALT freeze.
// Latency: 1 cycle PC->IF/ID; backpressure: i_stall (or a load) holds PC and IF/ID bit-exact.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC  = 32'h0,
    localparam int         ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_take_branch,
    input  logic [31:0]       i_branch_target_addr,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [31:0]       i_load_data,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_next_pc,
    output logic [31:0]       o_instruction,
    output logic              o_halted
);

    localparam ifid_t IFID_BUBBLE = '{next_pc: 32'h0, instr: NOP_INSTR};

    logic [31:0]  pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_word;
    logic [31:0]  pc_plus4;

    // Memory writes are independent of reset so the program can be loaded while reset is held.
    instruction_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .clk       (clk),
        .wr_en_i   (i_load_en),
        .wr_addr_i (i_load_addr),
        .wr_dat_i  (i_load_data),
        .rd_addr_i (pc_q[ADDR_W+1:2]),
        .rd_dat_o  (fetch_word)
    );

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        state_d = state_q;
        // A stalled branch is dropped; decode re-presents it once operands are ready.
        if (!i_load_en && !i_stall) begin
            if (i_take_branch) begin
                pc_d   = i_branch_target_addr;
                ifid_d = IFID_BUBBLE;
            end else if (state_q == HALTED) begin
                ifid_d = IFID_BUBBLE;
            end else if (fetch_word == HALT_INSTR) begin
                ifid_d  = '{next_pc: pc_plus4, instr: HALT_INSTR};
                state_d = HALTED;
            end else begin
                ifid_d = '{next_pc: pc_plus4, instr: fetch_word};
                pc_d   = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            ifid_q  <= IFID_BUBBLE;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            state_q <= state_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_next_pc     = ifid_q.next_pc;
    assign o_instruction = ifid_q.instr;
    assign o_halted      = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected PC / IF/ID / halt values are queued per edge
// and popped and compared one cycle later.
module tb_if_stage;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_stall;
    logic              i_take_branch;
    logic [31:0]       i_branch_target_addr;
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic [31:0]       i_load_data;
    logic [31:0]       o_pc;
    logic [31:0]       o_next_pc;
    logic [31:0]       o_instruction;
    logic              o_halted;

    always #5 clk = ~clk;

    if_stage #(
        .MEM_DEPTH (MEM_DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .i_stall              (i_stall),
        .i_take_branch        (i_take_branch),
        .i_branch_target_addr (i_branch_target_addr),
        .i_load_en            (i_load_en),
        .i_load_addr          (i_load_addr),
        .i_load_data          (i_load_data),
        .o_pc                 (o_pc),
        .o_next_pc            (o_next_pc),
        .o_instruction        (o_instruction),
        .o_halted             (o_halted)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ins;
        logic        halt;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Queue what the next edge must produce, advance one edge, then pop and compare.
    task automatic cyc(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] ins, input logic halt);
        exp_t e;
        sb_q.push_back('{pc, npc, ins, halt});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".pc"},    o_pc,              e.pc);
            chk({tag, ".npc"},   o_next_pc,         e.npc);
            chk({tag, ".instr"}, o_instruction,     e.ins);
            chk({tag, ".halt"},  {31'b0, o_halted}, {31'b0, e.halt});
        end
    endtask

    task automatic idle();
        reset         = 1'b0;
        i_stall       = 1'b0;
        i_take_branch = 1'b0;
        i_load_en     = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        i_stall              = 1'b0;
        i_take_branch        = 1'b0;
        i_branch_target_addr = 32'h0;
        i_load_en            = 1'b0;
        i_load_addr          = '0;
        i_load_data          = 32'h0;

        // Program load under reset: filler words 0x1000_00ii, program at 0..2.
        for (int i = 0; i < MEM_DEPTH; i++) begin
            i_load_en   = 1'b1;
            i_load_addr = ADDR_W'(i);
            case (i)
                0:       i_load_data = 32'h2001_0005;
                1:       i_load_data = 32'h2002_0007;
                2:       i_load_data = HALT;
                default: i_load_data = 32'h1000_0000 + 32'(i);
            endcase
            @(posedge clk);
            #1;
        end
        i_load_en = 1'b0;
        cyc("reset", 32'h0, 32'h0, NOP, 1'b0);

        // Straight-line fetch into HALT.
        idle();
        cyc("f0",     32'h4, 32'h4,  32'h2001_0005, 1'b0);
        cyc("f1",     32'h8, 32'h8,  32'h2002_0007, 1'b0);
        cyc("f_halt", 32'h8, 32'hC,  HALT,          1'b1);
        cyc("halted", 32'h8, 32'h0,  NOP,           1'b1);

        // Branch while halted redirects but stays halted.
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'h40;
        cyc("halt_br",  32'h40, 32'h0, NOP, 1'b1);
        i_take_branch = 1'b0;
        cyc("halt_br2", 32'h40, 32'h0, NOP, 1'b1);

        // Load while halted holds all state; then reset.
        i_load_en   = 1'b1;
        i_load_addr = 8'd2;
        i_load_data = 32'h2003_0009;
        cyc("halt_load", 32'h40, 32'h0, NOP, 1'b1);
        i_load_en = 1'b0;
        reset     = 1'b1;
        cyc("reset2", 32'h0, 32'h0, NOP, 1'b0);

        // Stall three cycles at PC=0x08 with a branch in the middle cycle.
        idle();
        cyc("r0", 32'h4, 32'h4, 32'h2001_0005, 1'b0);
        cyc("r1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
        i_stall = 1'b1;
        cyc("stall1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'h80;
        cyc("stall2", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
        i_take_branch = 1'b0;
        cyc("stall3", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
        i_stall = 1'b0;
        cyc("resume", 32'hC,  32'hC,  32'h2003_0009, 1'b0);
        cyc("r3",     32'h10, 32'h10, 32'h1000_0003, 1'b0);

        // Taken branch at PC=0x10: one bubble, then target.
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'h40;
        cyc("br_bubble", 32'h40, 32'h0, NOP, 1'b0);
        i_take_branch = 1'b0;
        cyc("br_target", 32'h44, 32'h44, 32'h1000_0010, 1'b0);

        // Wrong-path HALT at 0x0C flushed by a branch to 0x20.
        i_load_en   = 1'b1;
        i_load_addr = 8'd3;
        i_load_data = HALT;
        cyc("load_hold", 32'h44, 32'h44, 32'h1000_0010, 1'b0);
        i_load_en = 1'b0;
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'hC;
        cyc("to_halt_pc", 32'hC, 32'h0, NOP, 1'b0);
        i_branch_target_addr = 32'h20;
        cyc("flush_halt", 32'h20, 32'h0, NOP, 1'b0);
        i_take_branch = 1'b0;
        cyc("after_flush", 32'h24, 32'h24, 32'h1000_0008, 1'b0);

        // Address wrap modulo MEM_DEPTH*4.
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'(MEM_DEPTH * 4 + 4);
        cyc("wrap_br", 32'h404, 32'h0, NOP, 1'b0);
        i_take_branch = 1'b0;
        cyc("wrap_fetch", 32'h408, 32'h408, 32'h2002_0007, 1'b0);

        // PC+4 wraps at 2^32.
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'hFFFF_FFFC;
        cyc("top_br", 32'hFFFF_FFFC, 32'h0, NOP, 1'b0);
        i_take_branch = 1'b0;
        cyc("top_fetch", 32'h0, 32'h0, 32'h1000_00FF, 1'b0);
        cyc("top_next",  32'h4, 32'h4, 32'h2001_0005, 1'b0);

        // Reset wins over stall, branch and load; program words stay intact.
        reset         = 1'b1;
        i_stall       = 1'b1;
        i_take_branch = 1'b1;
        i_branch_target_addr = 32'h80;
        i_load_en     = 1'b1;
        i_load_addr   = 8'd200;
        i_load_data   = 32'hDEAD_BEEF;
        cyc("rst_mix", 32'h0, 32'h0, NOP, 1'b0);
        idle();
        cyc("post_rst0", 32'h4, 32'h4, 32'h2001_0005, 1'b0);
        cyc("post_rst1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
